dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_strobe_gen.sv | 50 +++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-counter width.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } dmem_state_t;

endpackage

// File: rtl/dmem_strobe_gen.sv
// Byte-lane enables, lane-replicated store data and misalignment flag for one
// access. The flag is only raised when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_strobe_gen
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misalign
);

   // lane selection and data replication by access size
   always_comb begin
      be        = 4'b0000;
      wdata_rep = wdata;
      misalign  = 1'b0;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be        = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign  = addr[0];
`else
            misalign  = 1'b0;
`endif
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_rep = wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign  = |addr;
`else
            misalign  = 1'b0;
`endif
         end
         default: begin
            be        = 4'b0000;
            wdata_rep = wdata;
            misalign  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte strobes and programmable
// wait states. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int MP_DATA_WIDTH  = 32,
   parameter int MP_ADDR_WIDTH  = 32,
   parameter int MP_DEPTH_WORDS = 1024,
   parameter int MP_WAIT_CYCLES = 0
) (
   input  logic                     iclk,
   input  logic                     irst,
   input  logic                     ireq,
   input  logic                     iwe,
   input  logic [1:0]               isize,
   input  logic [MP_ADDR_WIDTH-1:0] iaddr,
   input  logic [MP_DATA_WIDTH-1:0] iwdata,
   output logic                     oready,
   output logic                     ovalid,
   output logic [MP_DATA_WIDTH-1:0] ordata,
   output logic                     oerr
);

   localparam int IDX_W = $clog2(MP_DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] CNT_ZERO  = {WAIT_CNT_W{1'b0}};
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (MP_WAIT_CYCLES > 0) ? WAIT_CNT_W'(MP_WAIT_CYCLES - 1) : CNT_ZERO;

   dmem_state_t state_r, state_n_s;
   logic [WAIT_CNT_W-1:0]    cnt_r, cnt_n_s;
   logic [IDX_W-1:0]         idx_r, sel_idx_s;
   logic [1:0]               lane_r, sel_lane_s;
   logic [1:0]               size_r, sel_size_s;
   logic [MP_DATA_WIDTH-1:0] wdata_r, sel_wdata_s;
   logic                     we_r;
   logic                     accept_s, in_idle_s, resp_n_s;
   logic [3:0]               be_s;
   logic [MP_DATA_WIDTH-1:0] wdata_rep_s;
   logic                     misalign_s;
   logic                     oready_r, ovalid_r, oerr_r;
   logic [MP_DATA_WIDTH-1:0] ordata_r;
   logic [MP_DATA_WIDTH-1:0] mem_r [MP_DEPTH_WORDS];
   logic                     unused_addr_s;

   assign unused_addr_s = ^iaddr[MP_ADDR_WIDTH-1:IDX_W+2];

   // While idle the strobe logic looks at the live request so that a
   // zero-wait access can be decoded on the accepting edge.
   assign in_idle_s   = (state_r == IDLE);
   assign sel_idx_s   = in_idle_s ? iaddr[IDX_W+1:2] : idx_r;
   assign sel_lane_s  = in_idle_s ? iaddr[1:0]       : lane_r;
   assign sel_size_s  = in_idle_s ? isize            : size_r;
   assign sel_wdata_s = in_idle_s ? iwdata           : wdata_r;
   assign accept_s    = ireq & oready_r;
   assign resp_n_s    = (state_n_s == RESP);

   dmem_strobe_gen u_strobe (
      .size      (sel_size_s),
      .addr      (sel_lane_s),
      .wdata     (sel_wdata_s),
      .be        (be_s),
      .wdata_rep (wdata_rep_s),
      .misalign  (misalign_s)
   );

   // next-state and wait-counter logic
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (MP_WAIT_CYCLES > 0) begin
                  state_n_s = WAIT;
                  cnt_n_s   = WAIT_LOAD;
               end else begin
                  state_n_s = RESP;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_n_s = RESP;
            end else begin
               cnt_n_s = cnt_r - CNT_ONE;
            end
         end
         RESP:    state_n_s = IDLE;
         default: state_n_s = IDLE;
      endcase
   end

   // state and output registers; outputs are decoded from the next state
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         oready_r <= 1'b0;
         ovalid_r <= 1'b0;
         ordata_r <= {MP_DATA_WIDTH{1'b0}};
         oerr_r   <= 1'b0;
      end else begin
         state_r  <= state_n_s;
         cnt_r    <= cnt_n_s;
         oready_r <= (state_n_s == IDLE);
         ovalid_r <= resp_n_s;
         oerr_r   <= resp_n_s & misalign_s;
         if (resp_n_s) begin
            ordata_r <= mem_r[sel_idx_s];
         end
      end
   end

   // request capture on accept
   always_ff @(posedge iclk) begin
      if (accept_s) begin
         idx_r   <= iaddr[IDX_W+1:2];
         lane_r  <= iaddr[1:0];
         size_r  <= isize;
         wdata_r <= iwdata;
         we_r    <= iwe;
      end
   end

   // store commit at the end of RESP; a trapped access writes nothing
   always_ff @(posedge iclk) begin
      if (!irst && (state_r == RESP) && we_r && !misalign_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[idx_r][8*i +: 8] <= wdata_rep_s[8*i +: 8];
            end
         end
      end
   end

   assign oready = oready_r;
   assign ovalid = ovalid_r;
   assign ordata = ordata_r;
   assign oerr   = oerr_r;

endmodule
